// File: rtl/v810_sysreg_ctx.sv
// rtl/v810_sysreg_ctx.sv - V810 system register file with exception entry / RETI context engine.
// Optional ADTRE register and address-trap hit output under V810_SYSREG_ADTRE_EN.
module v810_sysreg_ctx #(
    parameter logic [31:0] PIR_VALUE  = 32'h0000_8100,
    parameter logic [31:0] TKCW_VALUE = 32'h0000_00E0,
    parameter logic [31:0] CHCW_MASK  = 32'h0000_0002
) (
    input  logic        i_clk,
    input  logic        i_resn,
    input  logic        i_ce,
    input  logic [4:0]  i_ra,
    output logic [31:0] o_rd,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic        i_we,
    output logic [31:0] o_psw,
    input  logic        i_exc_req,
    input  logic        i_exc_int,
    input  logic [3:0]  i_exc_lvl,
    input  logic [15:0] i_exc_cc,
    input  logic [31:0] i_exc_pc,
    output logic        o_exc_ack,
    input  logic        i_reti_req,
    output logic        o_reti_ack,
    output logic [31:0] o_reti_pc,
`ifdef V810_SYSREG_ADTRE_EN
    input  logic [31:0] i_adtre_pc,
    output logic        o_adtre_hit,
`endif
    output logic        o_fatal
);

    localparam logic [4:0] SR_EIPC  = 5'd0;
    localparam logic [4:0] SR_EIPSW = 5'd1;
    localparam logic [4:0] SR_FEPC  = 5'd2;
    localparam logic [4:0] SR_FEPSW = 5'd3;
    localparam logic [4:0] SR_ECR   = 5'd4;
    localparam logic [4:0] SR_PSW   = 5'd5;
    localparam logic [4:0] SR_PIR   = 5'd6;
    localparam logic [4:0] SR_TKCW  = 5'd7;
    localparam logic [4:0] SR_CHCW  = 5'd24;
`ifdef V810_SYSREG_ADTRE_EN
    localparam logic [4:0] SR_ADTRE = 5'd25;
`endif

    localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFE;
    localparam logic [31:0] PSW_MASK = 32'h000F_F3FF;

    localparam int PSW_ID = 12;
    localparam int PSW_AE = 13;
    localparam int PSW_EP = 14;
    localparam int PSW_NP = 15;

    typedef enum logic [2:0] {S_IDLE, S_SAVE, S_UPD, S_REST, S_HALT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_eipc;
    logic [31:0] r_eipsw;
    logic [31:0] r_fepc;
    logic [31:0] r_fepsw;
    logic [31:0] r_ecr;
    logic [31:0] r_psw;
    logic [31:0] r_chcw;
    logic [31:0] r_reti_pc;
    logic        r_fatal;
    logic        r_lat_int;
    logic [3:0]  r_lat_lvl;
    logic [15:0] r_lat_cc;
    logic [31:0] r_lat_pc;
    logic        r_lat_ep;
    logic [31:0] w_rd;
    logic [31:0] w_psw_upd;
    logic [31:0] w_reti_src;
    logic [4:0]  w_lvl_inc;
`ifdef V810_SYSREG_ADTRE_EN
    logic [31:0] r_adtre;
    logic        r_adtre_match_d;
    logic        w_adtre_match;
`endif

    always_ff @(posedge i_clk or negedge i_resn) begin
        if (!i_resn) begin
            r_state <= S_IDLE;
        end else if (i_ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_exc_ack   = 1'b0;
        o_reti_ack  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_exc_req) begin
                    w_state_nxt = r_psw[PSW_NP] ? S_HALT : S_SAVE;
                end else if (i_reti_req) begin
                    w_state_nxt = S_REST;
                end
            end
            S_SAVE: w_state_nxt = S_UPD;
            S_UPD: begin
                w_state_nxt = S_IDLE;
                o_exc_ack   = i_ce;
            end
            S_REST: begin
                w_state_nxt = S_IDLE;
                o_reti_ack  = i_ce;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Exception-level PSW update: the level chosen in SAVE decides EP vs NP.
    always_comb begin
        w_lvl_inc = {1'b0, r_lat_lvl} + 5'd1;
        w_psw_upd = r_psw;
        if (r_lat_ep) begin
            w_psw_upd[PSW_NP] = 1'b1;
        end else begin
            w_psw_upd[PSW_EP] = 1'b1;
        end
        w_psw_upd[PSW_ID] = 1'b1;
        w_psw_upd[PSW_AE] = 1'b0;
        if (r_lat_int) begin
            w_psw_upd[19:16] = w_lvl_inc[4] ? 4'hF : w_lvl_inc[3:0];
        end
    end

    assign w_reti_src = r_psw[PSW_NP] ? r_fepc : r_eipc;

    // LDSR is applied first so that FSM writes later in the block take priority.
    always_ff @(posedge i_clk or negedge i_resn) begin
        if (!i_resn) begin
            r_eipc    <= '0;
            r_eipsw   <= '0;
            r_fepc    <= '0;
            r_fepsw   <= '0;
            r_ecr     <= '0;
            r_psw     <= 32'h0000_8000;
            r_chcw    <= '0;
            r_reti_pc <= '0;
            r_fatal   <= 1'b0;
            r_lat_int <= 1'b0;
            r_lat_lvl <= '0;
            r_lat_cc  <= '0;
            r_lat_pc  <= '0;
            r_lat_ep  <= 1'b0;
        end else if (i_ce) begin
            if (i_we) begin
                case (i_wa)
                    SR_EIPC:  r_eipc  <= i_wd & PC_MASK;
                    SR_EIPSW: r_eipsw <= i_wd & PSW_MASK;
                    SR_FEPC:  r_fepc  <= i_wd & PC_MASK;
                    SR_FEPSW: r_fepsw <= i_wd & PSW_MASK;
                    SR_PSW:   r_psw   <= i_wd & PSW_MASK;
                    SR_CHCW:  r_chcw  <= i_wd & CHCW_MASK;
                    default: ;
                endcase
            end
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_SAVE) begin
                        r_lat_int <= i_exc_int;
                        r_lat_lvl <= i_exc_lvl;
                        r_lat_cc  <= i_exc_cc;
                        r_lat_pc  <= i_exc_pc & PC_MASK;
                    end
                    if (w_state_nxt == S_HALT) begin
                        r_fatal <= 1'b1;
                    end
                end
                S_SAVE: begin
                    r_lat_ep <= r_psw[PSW_EP];
                    if (r_psw[PSW_EP]) begin
                        r_fepc        <= r_lat_pc;
                        r_fepsw       <= r_psw;
                        r_ecr[31:16]  <= r_lat_cc;
                    end else begin
                        r_eipc        <= r_lat_pc;
                        r_eipsw       <= r_psw;
                        r_ecr[15:0]   <= r_lat_cc;
                    end
                end
                S_UPD: r_psw <= w_psw_upd;
                S_REST: begin
                    r_psw     <= r_psw[PSW_NP] ? r_fepsw : r_eipsw;
                    r_reti_pc <= w_reti_src;
                end
                default: ;
            endcase
        end
    end

`ifdef V810_SYSREG_ADTRE_EN
    always_ff @(posedge i_clk or negedge i_resn) begin
        if (!i_resn) begin
            r_adtre         <= '0;
            r_adtre_match_d <= 1'b0;
        end else if (i_ce) begin
            if (i_we && (i_wa == SR_ADTRE)) begin
                r_adtre <= i_wd & PC_MASK;
            end
            r_adtre_match_d <= w_adtre_match;
        end
    end

    assign w_adtre_match = r_psw[PSW_AE] && (i_adtre_pc == r_adtre);
    assign o_adtre_hit   = w_adtre_match && !r_adtre_match_d;
`endif

    always_comb begin
        w_rd = '0;
        case (i_ra)
            SR_EIPC:  w_rd = r_eipc;
            SR_EIPSW: w_rd = r_eipsw;
            SR_FEPC:  w_rd = r_fepc;
            SR_FEPSW: w_rd = r_fepsw;
            SR_ECR:   w_rd = r_ecr;
            SR_PSW:   w_rd = r_psw;
            SR_PIR:   w_rd = PIR_VALUE;
            SR_TKCW:  w_rd = TKCW_VALUE;
            SR_CHCW:  w_rd = r_chcw;
`ifdef V810_SYSREG_ADTRE_EN
            SR_ADTRE: w_rd = r_adtre;
`endif
            default:  w_rd = '0;
        endcase
    end

    // RETI_PC is live in the ack cycle, then held in a register.
    assign o_rd      = w_rd;
    assign o_psw     = r_psw;
    assign o_fatal   = r_fatal;
    assign o_reti_pc = (r_state == S_REST) ? w_reti_src : r_reti_pc;

endmodule

// File: tb/tb_v810_sysreg_ctx.sv
// tb/tb_v810_sysreg_ctx.sv - directed self-checking bench for v810_sysreg_ctx.
module tb_v810_sysreg_ctx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    logic [31:0] psw;
    logic        exc_req;
    logic        exc_int;
    logic [3:0]  exc_lvl;
    logic [15:0] exc_cc;
    logic [31:0] exc_pc;
    logic        exc_ack;
    logic        reti_req;
    logic        reti_ack;
    logic [31:0] reti_pc;
    logic        fatal;
`ifdef V810_SYSREG_ADTRE_EN
    logic [31:0] adtre_pc = '0;
    logic        adtre_hit;
`endif

    int n_vec = 0;
    int n_err = 0;

    v810_sysreg_ctx dut (
        .i_clk      (clk),
        .i_resn     (rst_n),
        .i_ce       (ce),
        .i_ra       (ra),
        .o_rd       (rd),
        .i_wa       (wa),
        .i_wd       (wd),
        .i_we       (we),
        .o_psw      (psw),
        .i_exc_req  (exc_req),
        .i_exc_int  (exc_int),
        .i_exc_lvl  (exc_lvl),
        .i_exc_cc   (exc_cc),
        .i_exc_pc   (exc_pc),
        .o_exc_ack  (exc_ack),
        .i_reti_req (reti_req),
        .o_reti_ack (reti_ack),
        .o_reti_pc  (reti_pc),
`ifdef V810_SYSREG_ADTRE_EN
        .i_adtre_pc (adtre_pc),
        .o_adtre_hit(adtre_hit),
`endif
        .o_fatal    (fatal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic ldsr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_sr(input logic [4:0] a, output logic [31:0] v);
        ra = a;
        #1;
        v = rd;
    endtask

    task automatic wait_exc_ack(output int lat);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (exc_ack === 1'b1) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    task automatic wait_reti_ack(output int lat);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (reti_ack === 1'b1) begin
                lat = n + 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [4:0]  codes [11];
        logic [31:0] exps  [11];
        logic [31:0] v;
        codes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd24, 5'd25, 5'd31};
        exps  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h8000, 32'h8100, 32'hE0, 32'h0, 32'h0, 32'h0};
        @(negedge clk);
        n_vec++; if (exc_ack !== 1'b0) begin n_err++; $display("FAIL reset_exc_ack got %0b want 0", exc_ack); end
        n_vec++; if (reti_ack !== 1'b0) begin n_err++; $display("FAIL reset_reti_ack got %0b want 0", reti_ack); end
        n_vec++; if (reti_pc !== 32'h0) begin n_err++; $display("FAIL reset_reti_pc got %h want 0", reti_pc); end
        n_vec++; if (fatal !== 1'b0) begin n_err++; $display("FAIL reset_fatal got %0b want 0", fatal); end
        for (int k = 0; k < 11; k++) begin
            rd_sr(codes[k], v);
            n_vec++;
            if (v !== exps[k]) begin
                n_err++;
                $display("FAIL reset_read sr%0d got %h want %h", codes[k], v, exps[k]);
            end
        end
    endtask

    task automatic test_ldsr;
        logic [31:0] v;
        ldsr(5'd1, 32'hFFFF_FFFF); rd_sr(5'd1, v);
        n_vec++; if (v !== 32'h000F_F3FF) begin n_err++; $display("FAIL ldsr_eipsw_mask got %h want 000ff3ff", v); end
        ldsr(5'd0, 32'h0000_1235); rd_sr(5'd0, v);
        n_vec++; if (v !== 32'h0000_1234) begin n_err++; $display("FAIL ldsr_eipc_bit0 got %h want 00001234", v); end
        ldsr(5'd24, 32'hFFFF_FFFF); rd_sr(5'd24, v);
        n_vec++; if (v !== 32'h0000_0002) begin n_err++; $display("FAIL ldsr_chcw_mask got %h want 00000002", v); end
        ldsr(5'd6, 32'h0); rd_sr(5'd6, v);
        n_vec++; if (v !== 32'h0000_8100) begin n_err++; $display("FAIL ldsr_pir_ro got %h want 00008100", v); end
        ldsr(5'd4, 32'hFFFF_FFFF); rd_sr(5'd4, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL ldsr_ecr_ro got %h want 0", v); end
        ldsr(5'd25, 32'hFFFF_FFFF);
`ifndef V810_SYSREG_ADTRE_EN
        rd_sr(5'd25, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL ldsr_sr25_ignored got %h want 0", v); end
`endif
        ldsr(5'd1, 32'h0);
        ldsr(5'd0, 32'h0);
        ldsr(5'd5, 32'h0);
        n_vec++; if (psw !== 32'h0) begin n_err++; $display("FAIL ldsr_psw_zero got %h want 0", psw); end
    endtask

    task automatic test_exception;
        int lat;
        logic [31:0] v;
        @(negedge clk);
        exc_req = 1'b1; exc_int = 1'b1; exc_lvl = 4'd3; exc_cc = 16'hFE30; exc_pc = 32'h1000;
        wait_exc_ack(lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL exc_latency got %0d want 3", lat); end
        exc_req = 1'b0;
        @(negedge clk);
        n_vec++; if (exc_ack !== 1'b0) begin n_err++; $display("FAIL exc_ack_single got %0b want 0", exc_ack); end
        n_vec++; if (psw !== 32'h0004_5000) begin n_err++; $display("FAIL exc_psw got %h want 00045000", psw); end
        rd_sr(5'd0, v);
        n_vec++; if (v !== 32'h0000_1000) begin n_err++; $display("FAIL exc_eipc got %h want 00001000", v); end
        rd_sr(5'd4, v);
        n_vec++; if (v !== 32'h0000_FE30) begin n_err++; $display("FAIL exc_ecr got %h want 0000fe30", v); end
        rd_sr(5'd1, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL exc_eipsw got %h want 0", v); end
    endtask

    task automatic test_nested;
        int lat;
        logic [31:0] v;
        @(negedge clk);
        exc_req = 1'b1; exc_int = 1'b0; exc_lvl = 4'd9; exc_cc = 16'hFFA0; exc_pc = 32'h2002;
        wait_exc_ack(lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL nest_latency got %0d want 3", lat); end
        exc_req = 1'b0;
        @(negedge clk);
        n_vec++; if (psw !== 32'h0004_D000) begin n_err++; $display("FAIL nest_psw got %h want 0004d000", psw); end
        rd_sr(5'd2, v);
        n_vec++; if (v !== 32'h0000_2002) begin n_err++; $display("FAIL nest_fepc got %h want 00002002", v); end
        rd_sr(5'd3, v);
        n_vec++; if (v !== 32'h0004_5000) begin n_err++; $display("FAIL nest_fepsw got %h want 00045000", v); end
        rd_sr(5'd4, v);
        n_vec++; if (v !== 32'hFFA0_FE30) begin n_err++; $display("FAIL nest_ecr got %h want ffa0fe30", v); end
        rd_sr(5'd0, v);
        n_vec++; if (v !== 32'h0000_1000) begin n_err++; $display("FAIL nest_eipc got %h want 00001000", v); end
    endtask

    task automatic test_reti;
        int lat;
        @(negedge clk);
        reti_req = 1'b1;
        wait_reti_ack(lat);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL reti1_latency got %0d want 2", lat); end
        n_vec++; if (reti_pc !== 32'h0000_2002) begin n_err++; $display("FAIL reti1_pc got %h want 00002002", reti_pc); end
        reti_req = 1'b0;
        @(negedge clk);
        n_vec++; if (psw !== 32'h0004_5000) begin n_err++; $display("FAIL reti1_psw got %h want 00045000", psw); end
        n_vec++; if (reti_pc !== 32'h0000_2002) begin n_err++; $display("FAIL reti1_pc_hold got %h want 00002002", reti_pc); end
        reti_req = 1'b1;
        wait_reti_ack(lat);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL reti2_latency got %0d want 2", lat); end
        n_vec++; if (reti_pc !== 32'h0000_1000) begin n_err++; $display("FAIL reti2_pc got %h want 00001000", reti_pc); end
        reti_req = 1'b0;
        @(negedge clk);
        n_vec++; if (psw !== 32'h0) begin n_err++; $display("FAIL reti2_psw got %h want 0", psw); end
    endtask

    task automatic test_collision;
        logic [31:0] v;
        @(negedge clk);
        exc_req = 1'b1; exc_int = 1'b0; exc_lvl = 4'd0; exc_cc = 16'h0010; exc_pc = 32'h3001;
        @(negedge clk);
        n_vec++; if (exc_ack !== 1'b0) begin n_err++; $display("FAIL coll_save_ack got %0b want 0", exc_ack); end
        we = 1'b1; wa = 5'd0; wd = 32'h0000_AAAA;
        @(negedge clk);
        n_vec++; if (exc_ack !== 1'b1) begin n_err++; $display("FAIL coll_upd_ack got %0b want 1", exc_ack); end
        rd_sr(5'd0, v);
        n_vec++; if (v !== 32'h0000_3000) begin n_err++; $display("FAIL coll_eipc_save_wins got %h want 00003000", v); end
        exc_req = 1'b0;
        we = 1'b1; wa = 5'd5; wd = 32'h0000_000F;
        @(negedge clk);
        we = 1'b0;
        n_vec++; if (psw !== 32'h0000_5000) begin n_err++; $display("FAIL coll_psw_fsm_wins got %h want 00005000", psw); end
        rd_sr(5'd4, v);
        n_vec++; if (v !== 32'hFFA0_0010) begin n_err++; $display("FAIL coll_ecr got %h want ffa00010", v); end
    endtask

    task automatic test_ce_stall;
        int lat;
        logic [31:0] v;
        @(negedge clk);
        reti_req = 1'b1;
        wait_reti_ack(lat);
        n_vec++; if (reti_pc !== 32'h0000_3000) begin n_err++; $display("FAIL stall_reti_pc got %h want 00003000", reti_pc); end
        reti_req = 1'b0;
        @(negedge clk);
        n_vec++; if (psw !== 32'h0) begin n_err++; $display("FAIL stall_reti_psw got %h want 0", psw); end
        exc_req = 1'b1; exc_int = 1'b1; exc_lvl = 4'd15; exc_cc = 16'h0001; exc_pc = 32'h4000;
        @(negedge clk);
        ce = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rd_sr(5'd0, v);
            n_vec++; if (exc_ack !== 1'b0 || v !== 32'h0000_3000) begin
                n_err++; $display("FAIL stall_frozen_%0d ack %0b eipc %h want ack 0 eipc 00003000", k, exc_ack, v);
            end
        end
        ce = 1'b1;
        @(negedge clk);
        n_vec++; if (exc_ack !== 1'b1) begin n_err++; $display("FAIL stall_resume_ack got %0b want 1", exc_ack); end
        rd_sr(5'd0, v);
        n_vec++; if (v !== 32'h0000_4000) begin n_err++; $display("FAIL stall_eipc got %h want 00004000", v); end
        exc_req = 1'b0;
        @(negedge clk);
        n_vec++; if (psw !== 32'h000F_5000) begin n_err++; $display("FAIL stall_psw_lvl_sat got %h want 000f5000", psw); end
        rd_sr(5'd4, v);
        n_vec++; if (v !== 32'hFFA0_0001) begin n_err++; $display("FAIL stall_ecr got %h want ffa00001", v); end
    endtask

    task automatic test_fatal;
        int lat;
        int acks;
        logic [31:0] v;
        ldsr(5'd5, 32'h0000_8000);
        exc_req = 1'b1; exc_int = 1'b0; exc_cc = 16'h0042; exc_pc = 32'h5000;
        wait_exc_ack(lat);
        n_vec++; if (lat !== 0) begin n_err++; $display("FAIL fatal_no_ack got latency %0d want none", lat); end
        n_vec++; if (fatal !== 1'b1) begin n_err++; $display("FAIL fatal_set got %0b want 1", fatal); end
        exc_req = 1'b0;
        reti_req = 1'b1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (reti_ack === 1'b1 || exc_ack === 1'b1) acks++;
        end
        reti_req = 1'b0;
        n_vec++; if (acks !== 0) begin n_err++; $display("FAIL halt_no_acks got %0d want 0", acks); end
        n_vec++; if (psw !== 32'h0000_8000) begin n_err++; $display("FAIL halt_psw_hold got %h want 00008000", psw); end
        rd_sr(5'd0, v);
        n_vec++; if (v !== 32'h0000_4000) begin n_err++; $display("FAIL halt_eipc_hold got %h want 00004000", v); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (fatal !== 1'b0) begin n_err++; $display("FAIL rst_fatal_clr got %0b want 0", fatal); end
        n_vec++; if (psw !== 32'h0000_8000) begin n_err++; $display("FAIL rst_psw got %h want 00008000", psw); end
        rd_sr(5'd0, v);
        n_vec++; if (v !== 32'h0) begin n_err++; $display("FAIL rst_eipc got %h want 0", v); end
        @(negedge clk);
        rst_n = 1'b1;
        ldsr(5'd5, 32'h0);
        exc_req = 1'b1; exc_int = 1'b0; exc_cc = 16'h0007; exc_pc = 32'h6000;
        wait_exc_ack(lat);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL post_halt_exc_latency got %0d want 3", lat); end
        exc_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; ra = '0; wa = '0; wd = '0; we = 1'b0;
        exc_req = 1'b0; exc_int = 1'b0; exc_lvl = '0; exc_cc = '0; exc_pc = '0; reti_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset;
        test_ldsr;
        test_exception;
        test_nested;
        test_reti;
        test_collision;
        test_ce_stall;
        test_fatal;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
